// File: rtl/cjtag_host_adapter.sv
// Probe-side cJTAG master: converts a command stream into TCKC/TMSC escapes,
// the online-activation code and OScan1 3-slot bit transfers, returning TDO.
module cjtag_host_adapter #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned SEL_TOGGLES = 6,
  parameter int unsigned RST_TOGGLES = 8,
  parameter logic [11:0] ACT_CODE    = 12'h00C
) (
  input  logic       clk_i,
  input  logic       ntrst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic       cmd_tms_i,
  input  logic       cmd_tdi_i,
  output logic       rsp_valid_o,
  output logic       rsp_tdo_o,
  output logic       rsp_err_o,
  output logic       tckc_o,
  output logic       tmsc_o,
  output logic       tmsc_oen_o,
  input  logic       tmsc_i,
  output logic       online_o,
  output logic       busy_o
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned TOG_MAX = (RST_TOGGLES > SEL_TOGGLES) ? RST_TOGGLES : SEL_TOGGLES;
  localparam int unsigned TOG_W   = $clog2(TOG_MAX + 1);
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned ACT_LEN = 12;

  localparam logic [1:0] OP_ONLINE = 2'd0;
  localparam logic [1:0] OP_BIT    = 2'd1;
  localparam logic [1:0] OP_RESET  = 2'd2;
  localparam logic [1:0] OP_IDLE   = 2'd3;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    BIT_S0    = 4'd1,
    BIT_S1    = 4'd2,
    BIT_S2    = 4'd3,
    ESC_RISE  = 4'd4,
    ESC_TOG   = 4'd5,
    ESC_FALL  = 4'd6,
    ACT_SHIFT = 4'd7,
    IDLE_CLK  = 4'd8,
    RSP       = 4'd9
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               phase_q, phase_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         op_q, op_d;
  logic               tms_q, tms_d;
  logic               tckc_q, tckc_d;
  logic               tmsc_q, tmsc_d;
  logic               oen_q, oen_d;
  logic               online_q, online_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_tdo_q, rsp_tdo_d;
  logic               rsp_err_q, rsp_err_d;

  logic               accept;
  logic               tick;
  logic               period_end;
  logic               phased;
  logic               last_act;
  logic [TOG_W-1:0]   tog_target;

  assign accept     = cmd_valid_i && (state_q == IDLE);
  assign tick       = (div_q == DIV_W'(CLK_DIV - 1));
  assign period_end = tick && phase_q;
  assign phased     = (state_q == BIT_S0) || (state_q == BIT_S1) || (state_q == BIT_S2) ||
                      (state_q == ACT_SHIFT) || (state_q == IDLE_CLK);
  assign last_act   = (idx_q == IDX_W'(ACT_LEN - 1));
  assign tog_target = (op_q == OP_ONLINE) ? TOG_W'(SEL_TOGGLES) : TOG_W'(RST_TOGGLES);

  // State and datapath registers; reset aborts any operation silently.
  always_ff @(posedge clk_i or negedge ntrst_i) begin
    if (!ntrst_i) begin
      state_q     <= IDLE;
      div_q       <= '0;
      phase_q     <= 1'b0;
      tog_q       <= '0;
      idx_q       <= '0;
      op_q        <= OP_ONLINE;
      tms_q       <= 1'b0;
      tckc_q      <= 1'b0;
      tmsc_q      <= 1'b1;
      oen_q       <= 1'b0;
      online_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tdo_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      tog_q       <= tog_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      tms_q       <= tms_d;
      tckc_q      <= tckc_d;
      tmsc_q      <= tmsc_d;
      oen_q       <= oen_d;
      online_q    <= online_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tdo_q   <= rsp_tdo_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (cmd_op_i)
            OP_BIT:   state_d = online_q ? BIT_S0 : RSP;
            OP_IDLE:  state_d = IDLE_CLK;
            default:  state_d = ESC_RISE;
          endcase
        end
      end
      BIT_S0:    if (period_end) state_d = BIT_S1;
      BIT_S1:    if (period_end) state_d = BIT_S2;
      BIT_S2:    if (period_end) state_d = RSP;
      ESC_RISE:  if (tick) state_d = ESC_TOG;
      ESC_TOG:   if (tick && (tog_q == tog_target)) state_d = ESC_FALL;
      ESC_FALL:  if (tick) state_d = (op_q == OP_ONLINE) ? ACT_SHIFT : RSP;
      ACT_SHIFT: if (period_end && last_act) state_d = RSP;
      IDLE_CLK:  if (period_end) state_d = RSP;
      RSP:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output and datapath next values; TMSC moves only with a falling TCKC
  // except inside the escape, where toggling under TCKC high is the point.
  always_comb begin
    div_d       = (state_q == IDLE || state_q == RSP || tick) ? '0 : div_q + DIV_W'(1);
    phase_d     = phase_q;
    tog_d       = tog_q;
    idx_d       = idx_q;
    op_d        = op_q;
    tms_d       = tms_q;
    tckc_d      = tckc_q;
    tmsc_d      = tmsc_q;
    oen_d       = oen_q;
    online_d    = online_q;
    rsp_valid_d = 1'b0;
    rsp_tdo_d   = 1'b0;
    rsp_err_d   = 1'b0;

    if (phased && tick) begin
      phase_d = ~phase_q;
      tckc_d  = ~phase_q;
    end

    unique case (state_q)
      IDLE: begin
        phase_d = 1'b0;
        if (accept) begin
          op_d  = cmd_op_i;
          tms_d = cmd_tms_i;
          tog_d = '0;
          idx_d = '0;
          unique case (cmd_op_i)
            OP_BIT: begin
              if (online_q) begin
                tmsc_d = ~cmd_tdi_i;
              end else begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
              end
            end
            OP_IDLE: tmsc_d = 1'b1;
            default: tckc_d = 1'b1;
          endcase
        end
      end
      BIT_S0: if (period_end) tmsc_d = tms_q;
      BIT_S1: if (period_end) oen_d = 1'b1;
      BIT_S2: begin
        if (period_end) begin
          oen_d       = 1'b0;
          tmsc_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_tdo_d   = tmsc_i;
        end
      end
      ESC_RISE: begin
        if (tick) begin
          tmsc_d = ~tmsc_q;
          tog_d  = TOG_W'(1);
        end
      end
      ESC_TOG: begin
        if (tick && (tog_q != tog_target)) begin
          tmsc_d = ~tmsc_q;
          tog_d  = tog_q + TOG_W'(1);
        end
      end
      ESC_FALL: begin
        if (tick) begin
          tckc_d  = 1'b0;
          phase_d = 1'b0;
          if (op_q == OP_ONLINE) begin
            tmsc_d = ACT_CODE[0];
            idx_d  = '0;
          end else begin
            tmsc_d      = 1'b1;
            online_d    = 1'b0;
            rsp_valid_d = 1'b1;
          end
        end
      end
      ACT_SHIFT: begin
        if (period_end) begin
          if (last_act) begin
            tmsc_d      = 1'b1;
            online_d    = 1'b1;
            rsp_valid_d = 1'b1;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            tmsc_d = ACT_CODE[idx_q + IDX_W'(1)];
          end
        end
      end
      IDLE_CLK: if (period_end) rsp_valid_d = 1'b1;
      RSP: ;
      default: ;
    endcase
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_tdo_o   = rsp_tdo_q;
  assign rsp_err_o   = rsp_err_q;
  assign tckc_o      = tckc_q;
  assign tmsc_o      = tmsc_q;
  assign tmsc_oen_o  = oen_q;
  assign online_o    = online_q;

endmodule

// File: tb/tb_cjtag_host_adapter.sv
// Bench for cjtag_host_adapter: vector table plus scoreboard of responses,
// with a wire-side monitor counting TCKC rises and TMSC toggles under TCKC high.
module tb_cjtag_host_adapter;

  localparam int unsigned DIV = 2;
  localparam logic [11:0] ACT = 12'h00C;
  localparam logic [1:0] OP_ONLINE = 2'd0, OP_BIT = 2'd1, OP_RESET = 2'd2, OP_IDLE = 2'd3;
  localparam int LAT_BIT    = 6 * DIV + 1;
  localparam int LAT_IDLE   = 2 * DIV + 1;
  localparam int LAT_ONLINE = 1 + (6 + 2 + 24) * DIV;
  localparam int LAT_RESET  = 1 + (8 + 2) * DIV;

  logic       clk_i = 1'b0;
  logic       ntrst_i = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic [1:0] cmd_op_i = 2'd0;
  logic       cmd_tms_i = 1'b0;
  logic       cmd_tdi_i = 1'b0;
  logic       tmsc_i;
  logic       cmd_ready_o, rsp_valid_o, rsp_tdo_o, rsp_err_o;
  logic       tckc_o, tmsc_o, tmsc_oen_o, online_o, busy_o;
  logic       tdo_drv = 1'b0;

  assign tmsc_i = tmsc_oen_o ? tdo_drv : tmsc_o;

  cjtag_host_adapter #(.CLK_DIV(DIV), .SEL_TOGGLES(6), .RST_TOGGLES(8), .ACT_CODE(ACT)) dut (
    .clk_i(clk_i), .ntrst_i(ntrst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_tms_i(cmd_tms_i), .cmd_tdi_i(cmd_tdi_i),
    .rsp_valid_o(rsp_valid_o), .rsp_tdo_o(rsp_tdo_o), .rsp_err_o(rsp_err_o),
    .tckc_o(tckc_o), .tmsc_o(tmsc_o), .tmsc_oen_o(tmsc_oen_o), .tmsc_i(tmsc_i),
    .online_o(online_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] op;
    logic       tms, tdi, tdo;
    logic       exp_tdo, exp_err, exp_online;
    int         exp_lat, exp_tog, exp_rise;
  } vec_t;

  typedef struct {
    logic        tdo, err, online, oen_rise;
    int          lat, tog, rise;
    logic [11:0] sr;
  } rsp_t;

  vec_t exp_q[$];
  rsp_t rsp_q[$];

  int n_chk = 0, n_fail = 0, n_exp = 0;

  // Wire monitor: per-command latency, TCKC rises and escape toggles.
  int          cyc = 0, acc = 0, tog = 0, rise = 0, n_rsp = 0;
  logic [11:0] sr = '0;
  logic        oen_r = 1'b0, p_ready = 1'b1, p_tckc = 1'b0, p_tmsc = 1'b1;

  always @(negedge clk_i) begin : mon
    int c, a, t, r;
    logic [11:0] s;
    logic o;
    rsp_t rec;
    c = cyc + 1; a = acc; t = tog; r = rise; s = sr; o = oen_r;
    if (p_ready && !cmd_ready_o) begin a = c - 1; t = 0; r = 0; end
    if (!p_tckc && tckc_o) begin r = r + 1; s = {tmsc_o, s[11:1]}; o = tmsc_oen_o; end
    if (p_tckc && tckc_o && (tmsc_o != p_tmsc)) t = t + 1;
    if (rsp_valid_o) begin
      rec.tdo = rsp_tdo_o; rec.err = rsp_err_o; rec.online = online_o; rec.oen_rise = o;
      rec.lat = c - a; rec.tog = t; rec.rise = r; rec.sr = s;
      rsp_q.push_back(rec);
      n_rsp <= n_rsp + 1;
    end
    cyc <= c; acc <= a; tog <= t; rise <= r; sr <= s; oen_r <= o;
    p_ready <= cmd_ready_o; p_tckc <= tckc_o; p_tmsc <= tmsc_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic tms, input logic tdi);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!cmd_ready_o && n < 500) begin @(negedge clk_i); n++; end
    if (!cmd_ready_o) begin
      n_chk++; n_fail++;
      $display("FAIL ready timeout: cmd_ready_o low for %0d cycles, required high", n);
    end
    cmd_op_i = op; cmd_tms_i = tms; cmd_tdi_i = tdi; cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic pop_check(input string tag, output logic tdo);
    vec_t e;
    rsp_t r;
    int n;
    n = 0; tdo = 1'b0;
    while (rsp_q.size() == 0 && n < 400) begin @(negedge clk_i); n++; end
    e = exp_q.pop_front();
    if (rsp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: no response after %0d cycles, required one", tag, n);
      return;
    end
    r = rsp_q.pop_front();
    tdo = r.tdo;
    check({tag, " tdo"},    32'(r.tdo),    32'(e.exp_tdo));
    check({tag, " err"},    32'(r.err),    32'(e.exp_err));
    check({tag, " online"}, 32'(r.online), 32'(e.exp_online));
    check({tag, " lat"},    32'(r.lat),    32'(e.exp_lat));
    check({tag, " tog"},    32'(r.tog),    32'(e.exp_tog));
    check({tag, " rise"},   32'(r.rise),   32'(e.exp_rise));
    if (e.op == OP_ONLINE) check({tag, " act bits"}, 32'(r.sr), 32'(ACT));
    if (e.op == OP_BIT && !e.exp_err) begin
      check({tag, " slots"}, 32'(r.sr[10:9]), 32'({e.tms, ~e.tdi}));
      check({tag, " s2 oen"}, 32'(r.oen_rise), 32'd1);
    end
  endtask

  task automatic run(input vec_t v, input string tag, output logic tdo);
    tdo_drv = v.tdo;
    exp_q.push_back(v);
    n_exp++;
    issue(v.op, v.tms, v.tdi);
    pop_check(tag, tdo);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic tms, input logic tdi, input logic tdo,
                              input logic e_tdo, input logic e_err, input logic e_on,
                              input int lat, input int tg, input int rs);
    vec_t v;
    v.op = op; v.tms = tms; v.tdi = tdi; v.tdo = tdo;
    v.exp_tdo = e_tdo; v.exp_err = e_err; v.exp_online = e_on;
    v.exp_lat = lat; v.exp_tog = tg; v.exp_rise = rs;
    return v;
  endfunction

  initial begin : wdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        tbl[10];
    logic        t;
    logic [31:0] word;
    logic [31:0] pat;
    int          base;

    tbl[0] = mk(OP_BIT,    1, 0, 1, 0, 1, 0, 1,          0, 0);
    tbl[1] = mk(OP_IDLE,   0, 0, 0, 0, 0, 0, LAT_IDLE,   0, 1);
    tbl[2] = mk(OP_ONLINE, 0, 0, 0, 0, 0, 1, LAT_ONLINE, 6, 13);
    tbl[3] = mk(OP_BIT,    1, 0, 1, 1, 0, 1, LAT_BIT,    0, 3);
    tbl[4] = mk(OP_BIT,    0, 1, 0, 0, 0, 1, LAT_BIT,    0, 3);
    tbl[5] = mk(OP_IDLE,   0, 0, 0, 0, 0, 1, LAT_IDLE,   0, 1);
    tbl[6] = mk(OP_ONLINE, 0, 0, 0, 0, 0, 1, LAT_ONLINE, 6, 13);
    tbl[7] = mk(OP_BIT,    0, 0, 1, 1, 0, 1, LAT_BIT,    0, 3);
    tbl[8] = mk(OP_RESET,  0, 0, 0, 0, 0, 0, LAT_RESET,  8, 1);
    tbl[9] = mk(OP_BIT,    1, 1, 1, 0, 1, 0, 1,          0, 0);

    // Reset state, held and after release.
    repeat (3) @(negedge clk_i);
    check("rst tckc", 32'(tckc_o), 32'd0);
    ntrst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle tckc",   32'(tckc_o),      32'd0);
    check("idle tmsc",   32'(tmsc_o),      32'd1);
    check("idle oen",    32'(tmsc_oen_o),  32'd0);
    check("idle online", 32'(online_o),    32'd0);
    check("idle ready",  32'(cmd_ready_o), 32'd1);
    check("idle busy",   32'(busy_o),      32'd0);
    check("idle rsp",    32'(rsp_valid_o), 32'd0);

    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("v%0d", i), t);

    // Data register read: 32 BIT transfers return the responder pattern LSB first.
    run(mk(OP_ONLINE, 0, 0, 0, 0, 0, 1, LAT_ONLINE, 6, 13), "rd online", t);
    pat = 32'h1DEAD3FF;
    word = '0;
    for (int i = 0; i < 32; i++) begin
      run(mk(OP_BIT, 1'(i == 31), 1'(i % 3 == 0), pat[i], pat[i], 0, 1, LAT_BIT, 0, 3),
          $sformatf("rd%0d", i), t);
      word[i] = t;
    end
    check("rd word", word, 32'h1DEAD3FF);

    // Asynchronous reset in the S1 high phase aborts without a response.
    base = n_exp;
    tdo_drv = 1'b0;
    issue(OP_BIT, 1'b0, 1'b0);
    repeat (6) @(posedge clk_i);
    #3;
    check("s1 tckc", 32'(tckc_o), 32'd1);
    check("s1 tmsc", 32'(tmsc_o), 32'd0);
    ntrst_i = 1'b0;
    #1;
    check("arst tckc",   32'(tckc_o),      32'd0);
    check("arst tmsc",   32'(tmsc_o),      32'd1);
    check("arst oen",    32'(tmsc_oen_o),  32'd0);
    check("arst online", 32'(online_o),    32'd0);
    check("arst ready",  32'(cmd_ready_o), 32'd1);
    check("arst rsp",    32'(rsp_valid_o), 32'd0);
    repeat (3) @(negedge clk_i);
    ntrst_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("abort rsp count", 32'(n_rsp), 32'(base));
    run(mk(OP_BIT,    1, 0, 1, 0, 1, 0, 1,          0, 0),  "post bit", t);
    run(mk(OP_ONLINE, 0, 0, 0, 0, 0, 1, LAT_ONLINE, 6, 13), "post online", t);
    run(mk(OP_BIT,    0, 1, 1, 1, 0, 1, LAT_BIT,    0, 3),  "post bit2", t);

    repeat (5) @(negedge clk_i);
    check("total rsp count", 32'(n_rsp), 32'(n_exp));
    check("stray rsp", 32'(rsp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
